// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation encodings, flag bit
// positions and the control FSM state type.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier producing the low WIDTH bits of A*B.
// One partial product is accumulated per enabled step; WIDTH steps per product.
module shift_add_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step_en,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplr_in,
    output logic [WIDTH-1:0] product,
    output logic             last_step
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplr_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CW-1:0]    cnt_reg;

    // Product reflects the accumulator after the step currently being taken,
    // so the caller can register it on the final step edge.
    assign product   = acc_reg + (mplr_reg[0] ? mcand_reg : '0);
    assign last_step = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_reg <= '0;
            mplr_reg  <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            mcand_reg <= mcand_in;
            mplr_reg  <= mplr_in;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (step_en) begin
            acc_reg   <= product;
            mcand_reg <= mcand_reg << 1;
            mplr_reg  <= mplr_reg >> 1;
            cnt_reg   <= last_step ? '0 : cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops complete on the accept edge, MUL runs
// through the shift-add multiplier. Result and NZCV flags are registered.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);

    localparam int SW = $clog2(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg;
    logic [3:0]       flags_reg;

    logic             accept, is_mul, is_sub;
    logic             mul_load, mul_step, mul_last;
    logic [WIDTH-1:0] mul_product;
    logic [3:0]       mul_flags;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shift_stage [0:SW];
    logic [WIDTH-1:0] alu_result;
    logic             alu_c, alu_v;
    logic [3:0]       alu_flags;

    assign ready    = (state_reg != ST_MUL);
    assign done     = (state_reg == ST_DONE);
    assign Result   = result_reg;
    assign ALUFlags = flags_reg;

    assign accept = start && ready;
    assign is_mul = (ALUControl == OP_MUL);
    assign is_sub = (ALUControl == OP_SUB);

    // Barrel shifter one bit wider than the operand; the extra top bit ends
    // up holding the last bit shifted out, i.e. the LSL carry.
    assign shift_stage[0] = {1'b0, A};
    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_shift
            assign shift_stage[gi+1] = B[gi] ? (shift_stage[gi] << (2 ** gi))
                                             : shift_stage[gi];
        end
    endgenerate

    assign b_eff = is_sub ? ~B : B;
    assign sum   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

    always_comb begin
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                alu_result = sum[WIDTH-1:0];
                alu_c      = sum[WIDTH];
                alu_v      = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_result = A & B;
            OP_ORR: alu_result = A | B;
            OP_EOR: alu_result = A ^ B;
            OP_LSL: begin
                alu_result = shift_stage[SW][WIDTH-1:0];
                alu_c      = shift_stage[SW][WIDTH];
            end
            OP_MOV: alu_result = B;
            default: alu_result = '0;
        endcase
        alu_flags         = '0;
        alu_flags[FLAG_N] = alu_result[WIDTH-1];
        alu_flags[FLAG_Z] = (alu_result == '0);
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_N] = mul_product[WIDTH-1];
        mul_flags[FLAG_Z] = (mul_product == '0);
    end

    always_comb begin
        state_next = state_reg;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        case (state_reg)
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_last) state_next = ST_DONE;
            end
            default: begin
                if (accept) begin
                    mul_load   = is_mul;
                    state_next = is_mul ? ST_MUL : ST_DONE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg <= '0;
            flags_reg  <= '0;
        end else if (accept && !is_mul) begin
            result_reg <= alu_result;
            flags_reg  <= alu_flags;
        end else if (mul_step && mul_last) begin
            result_reg <= mul_product;
            flags_reg  <= mul_flags;
        end
    end

    shift_add_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .load     (mul_load),
        .step_en  (mul_step),
        .mcand_in (A),
        .mplr_in  (B),
        .product  (mul_product),
        .last_step(mul_last)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: 32-bit and 8-bit instances checked every cycle against a
// transaction-level model, plus directed vectors with literal expectations.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic [2:0]  op32, op8;
    logic        ready32, done32, ready8, done8;
    logic [31:0] res32;
    logic [7:0]  res8;
    logic [3:0]  flags32, flags8;

    int total  = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .A(a32), .B(b32),
        .ALUControl(op32), .ready(ready32), .done(done32),
        .Result(res32), .ALUFlags(flags32)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8),
        .ALUControl(op8), .ready(ready8), .done(done8),
        .Result(res8), .ALUFlags(flags8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Arithmetic meaning of each op; returns {N,Z,C,V, result}.
    function automatic logic [67:0] compute(int w, logic [2:0] op, logic [63:0] a_in, logic [63:0] b_in);
        logic [63:0] mask, a, b, bi, s, r;
        logic c, v;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        r = 0; c = 0; v = 0;
        case (op)
            3'd0, 3'd1: begin
                bi = (op == 3'd1) ? (~b & mask) : b;
                s  = a + bi + ((op == 3'd1) ? 64'd1 : 64'd0);
                r  = s & mask;
                c  = s[w];
                v  = (a[w-1] == bi[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                sh = int'(b % 64'(w));
                r  = (a << sh) & mask;
                c  = (sh == 0) ? 1'b0 : a[w-sh];
            end
            3'd6: r = (a * b) & mask;
            default: r = b;
        endcase
        return {r[w-1], (r == 64'd0), c, v, r};
    endfunction

    typedef struct {
        logic [63:0] res;
        logic [3:0]  flags;
        bit          done;
        int          busy;
        logic [63:0] pend_res;
        logic [3:0]  pend_flags;
    } mstate_t;

    function automatic mstate_t model_step(mstate_t s, int w, bit rst, bit st,
                                           logic [2:0] op, logic [63:0] a, logic [63:0] b);
        mstate_t n;
        logic [67:0] rf;
        n = s;
        n.done = 0;
        if (rst) begin
            n.res = 0; n.flags = 0; n.busy = 0;
            return n;
        end
        if (s.busy > 0) begin
            n.busy = s.busy - 1;
            if (n.busy == 0) begin
                n.res = s.pend_res; n.flags = s.pend_flags; n.done = 1;
            end
        end else if (st) begin
            rf = compute(w, op, a, b);
            if (op == 3'd6) begin
                n.busy = w; n.pend_res = rf[63:0]; n.pend_flags = rf[67:64];
            end else begin
                n.res = rf[63:0]; n.flags = rf[67:64]; n.done = 1;
            end
        end
        return n;
    endfunction

    mstate_t m32, m8;
    bit valid = 0;

    always @(posedge clk) begin
        m32   <= model_step(m32, 32, reset, start32, op32, {32'd0, a32}, {32'd0, b32});
        m8    <= model_step(m8, 8, reset, start8, op8, {56'd0, a8}, {56'd0, b8});
        valid <= valid | reset;
    end

    always @(negedge clk) begin
        if (valid) begin
            check("model_res32",   res32,   m32.res);
            check("model_flags32", flags32, m32.flags);
            check("model_done32",  done32,  m32.done);
            check("model_ready32", ready32, m32.busy == 0);
            check("model_res8",    res8,    m8.res);
            check("model_flags8",  flags8,  m8.flags);
            check("model_done8",   done8,   m8.done);
            check("model_ready8",  ready8,  m8.busy == 0);
        end
    end

    // Called at a falling edge; the op is accepted at the next rising edge.
    task automatic op32_run(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_r, input logic [3:0] exp_f);
        start32 = 1; op32 = op; a32 = a; b32 = b;
        @(negedge clk);
        start32 = 0;
        check({name, "_done"}, done32, 1);
        check({name, "_res"}, res32, exp_r);
        check({name, "_flags"}, flags32, exp_f);
        $display("op %s A=%h B=%h -> Result=%h flags=%b", name, a, b, res32, flags32);
    endtask

    int lowcnt, donecnt, first_done;
    logic [31:0] mul_res;
    logic [3:0]  mul_flags;

    initial begin
        reset = 1; start32 = 0; start8 = 0;
        a32 = 0; b32 = 0; op32 = 0; a8 = 0; b8 = 0; op8 = 0;
        repeat (3) @(negedge clk);
        check("rst_res", res32, 0);
        check("rst_flags", flags32, 0);
        check("rst_ready", ready32, 1);
        check("rst_done", done32, 0);
        reset = 0;
        @(negedge clk);

        op32_run("add_ovf", 3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001);
        op32_run("sub_eq",  3'b001, 32'h5, 32'h5, 32'h0, 4'b0110);
        op32_run("sub_neg", 3'b001, 32'h0, 32'h1, 32'hFFFFFFFF, 4'b1000);
        op32_run("lsl",     3'b101, 32'h80000001, 32'h1, 32'h00000002, 4'b0010);
        op32_run("eor",     3'b100, 32'hFFFF0000, 32'hFFFF0000, 32'h0, 4'b0100);
        op32_run("mov",     3'b111, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'b1000);

        // MUL with an ADD start injected mid-operation.
        start32 = 1; op32 = 3'b110; a32 = 32'h1234; b32 = 32'h10;
        @(negedge clk);
        start32 = 0;
        lowcnt = 0; donecnt = 0; first_done = 0; mul_res = 0; mul_flags = 0;
        for (int k = 1; k <= 45; k++) begin
            if (!ready32) lowcnt++;
            if (done32) begin
                donecnt++;
                if (first_done == 0) begin
                    first_done = k; mul_res = res32; mul_flags = flags32;
                end
            end
            if (k == 5) begin
                start32 = 1; op32 = 3'b000; a32 = 32'h1; b32 = 32'h1;
            end else begin
                start32 = 0;
            end
            @(negedge clk);
        end
        check("mul_latency", first_done, 33);
        check("mul_ready_low", lowcnt, 32);
        check("mul_done_count", donecnt, 1);
        check("mul_res", mul_res, 32'h00012340);
        check("mul_flags", mul_flags, 4'b0000);
        $display("op mul A=1234 B=10 -> Result=%h flags=%b latency=%0d", mul_res, mul_flags, first_done);

        // Reset at MUL step 10 aborts the multiply.
        start32 = 1; op32 = 3'b110; a32 = 32'h7; b32 = 32'h9;
        @(negedge clk);
        start32 = 0;
        repeat (9) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("abort_res", res32, 0);
        check("abort_flags", flags32, 0);
        check("abort_ready", ready32, 1);
        check("abort_done", done32, 0);
        donecnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done32) donecnt++;
            @(negedge clk);
        end
        check("abort_no_done", donecnt, 0);
        $display("op mul aborted by reset, done pulses=%0d", donecnt);
        op32_run("add_after", 3'b000, 32'h2, 32'h3, 32'h5, 4'b0000);

        // WIDTH=8 back-to-back.
        start8 = 1; op8 = 3'b000; a8 = 8'hFF; b8 = 8'h01;
        @(negedge clk);
        op8 = 3'b011; a8 = 8'h0F; b8 = 8'hF0;
        check("w8_add_done", done8, 1);
        check("w8_add_res", res8, 8'h00);
        check("w8_add_flags", flags8, 4'b0110);
        $display("op w8 add FF+01 -> Result=%h flags=%b", res8, flags8);
        @(negedge clk);
        start8 = 0;
        check("w8_orr_done", done8, 1);
        check("w8_orr_res", res8, 8'hFF);
        check("w8_orr_flags", flags8, 4'b1000);
        $display("op w8 orr 0F|F0 -> Result=%h flags=%b", res8, flags8);
        @(negedge clk);
        check("w8_idle_done", done8, 0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
